// File: rtl/ntt_core_gf64_fmr.sv
// Final modular reduction for the GF64 NTT path: maps a signed partially reduced
// operand onto its canonical residue in [0, MOD_M), one operand per clock.
module ntt_core_gf64_fmr #(
   parameter int          MOD_NTT_W = 64,
   parameter int          IN_PIPE   = 1,
   parameter int          SIDE_W    = 1,
   parameter logic [1:0]  RST_SIDE  = 2'b00
) (
   input  logic                   clk,
   input  logic                   a_rst,
   input  logic [MOD_NTT_W+1:0]   z,
   input  logic                   in_avail,
   input  logic [SIDE_W-1:0]      in_side,
   output logic [MOD_NTT_W-1:0]   r,
   output logic                   out_avail,
   output logic [SIDE_W-1:0]      out_side
);

   // Handshake: a beat exists only where *_avail is 1; there is no ready/backpressure,
   // and data/side registers hold their last captured value while avail is 0.
   localparam int ZW = MOD_NTT_W + 2;
   localparam logic [ZW-1:0] ONE    = ZW'(1);
   localparam logic [ZW-1:0] MOD_M  = (ONE << MOD_NTT_W) - (ONE << (MOD_NTT_W / 2)) + ONE;
   localparam logic [ZW-1:0] MOD_M2 = MOD_M << 1;
   localparam logic [ZW-1:0] MOD_M3 = MOD_M + MOD_M2;

   logic                  s0_avail;
   logic [ZW-1:0]         s0_z;
   logic [SIDE_W-1:0]     s0_side;

   logic                  avail1_q, avail2_q;
   logic [ZW-1:0]         t_d, t_q;
   logic [MOD_NTT_W-1:0]  r_d, r_q;
   logic [SIDE_W-1:0]     side1_q, side2_q;

   if (IN_PIPE == 1) begin : g_in_pipe
      logic              availp_q;
      logic [ZW-1:0]     zp_q;
      logic [SIDE_W-1:0] sidep_q;

      always_ff @(posedge clk or posedge a_rst) begin
         if (a_rst) begin
            availp_q <= 1'b0;
            zp_q     <= '0;
         end else begin
            availp_q <= in_avail;
            if (in_avail) zp_q <= z;
         end
      end

      if (RST_SIDE[0]) begin : g_side_rst
         always_ff @(posedge clk or posedge a_rst) begin
            if (a_rst)         sidep_q <= {SIDE_W{RST_SIDE[1]}};
            else if (in_avail) sidep_q <= in_side;
         end
      end else begin : g_side_nrst
         always_ff @(posedge clk) begin
            if (in_avail) sidep_q <= in_side;
         end
      end

      assign s0_avail = availp_q;
      assign s0_z     = zp_q;
      assign s0_side  = sidep_q;
   end else begin : g_no_in_pipe
      assign s0_avail = in_avail;
      assign s0_z     = z;
      assign s0_side  = in_side;
   end

   // Sign fold: adding 3*MOD_M to any negative input lands in [0, 3*MOD_M).
   always_comb begin
      t_d = s0_z + (s0_z[ZW-1] ? MOD_M3 : '0);
   end

   // t - 2M >= 0 and t - M >= 0 are evaluated as parallel magnitude compares;
   // the chosen difference is below MOD_M, so only its low MOD_NTT_W bits matter.
   always_comb begin
      r_d = t_q[MOD_NTT_W-1:0];
      if (t_q >= MOD_M2)     r_d = t_q[MOD_NTT_W-1:0] - MOD_M2[MOD_NTT_W-1:0];
      else if (t_q >= MOD_M) r_d = t_q[MOD_NTT_W-1:0] - MOD_M[MOD_NTT_W-1:0];
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         avail1_q <= 1'b0;
         avail2_q <= 1'b0;
         t_q      <= '0;
         r_q      <= '0;
      end else begin
         avail1_q <= s0_avail;
         avail2_q <= avail1_q;
         if (s0_avail) t_q <= t_d;
         if (avail1_q) r_q <= r_d;
      end
   end

   if (RST_SIDE[0]) begin : g_chain_rst
      always_ff @(posedge clk or posedge a_rst) begin
         if (a_rst) begin
            side1_q <= {SIDE_W{RST_SIDE[1]}};
            side2_q <= {SIDE_W{RST_SIDE[1]}};
         end else begin
            if (s0_avail) side1_q <= s0_side;
            if (avail1_q) side2_q <= side1_q;
         end
      end
   end else begin : g_chain_nrst
      always_ff @(posedge clk) begin
         if (s0_avail) side1_q <= s0_side;
         if (avail1_q) side2_q <= side1_q;
      end
   end

   assign r         = r_q;
   assign out_avail = avail2_q;
   assign out_side  = side2_q;

endmodule

// File: tb/tb_ntt_core_gf64_fmr.sv
// Bench for ntt_core_gf64_fmr: directed boundary operands, gapped and streaming random
// traffic, and an asynchronous mid-stream reset, checked against a wide-integer model.
module tb_ntt_core_gf64_fmr;

   localparam int W       = 64;
   localparam int IN_PIPE = 1;
   localparam int LAT     = IN_PIPE + 2;
   localparam int SW      = 8;
   localparam int EW      = W + SW + 1;

   logic          clk;
   logic          a_rst;
   logic [W+1:0]  z;
   logic          in_avail;
   logic [SW-1:0] in_side;
   logic [W-1:0]  r;
   logic          out_avail;
   logic [SW-1:0] out_side;

   int checks;
   int errors;

   // expected queue entries: {avail, residue, side}
   logic [EW-1:0] exp_q[$];
   logic [W-1:0]  last_r;
   logic [SW-1:0] last_s;

   logic [W+1:0]  mm;
   logic [W+1:0]  bnd[10];

   ntt_core_gf64_fmr #(
      .MOD_NTT_W (W),
      .IN_PIPE   (IN_PIPE),
      .SIDE_W    (SW),
      .RST_SIDE  (2'b11)
   ) dut (
      .clk       (clk),
      .a_rst     (a_rst),
      .z         (z),
      .in_avail  (in_avail),
      .in_side   (in_side),
      .r         (r),
      .out_avail (out_avail),
      .out_side  (out_side)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // residue of a signed 66-bit value, using 128-bit signed arithmetic
   function automatic logic [W-1:0] ref_mod(input logic [W+1:0] zin);
      logic signed [127:0] m, zz, rr;
      m  = (128'sd1 <<< 64) - (128'sd1 <<< 32) + 128'sd1;
      zz = {{62{zin[W+1]}}, zin};
      rr = zz % m;
      if (rr < 0) rr = rr + m;
      return rr[W-1:0];
   endfunction

   function automatic logic [W+1:0] rand_z();
      logic [W+1:0] v;
      if ($urandom_range(0, 7) == 0) v = bnd[$urandom_range(0, 9)];
      else v = {$urandom_range(0, 3), $urandom, $urandom};
      return v;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      repeat (LAT - 1) exp_q.push_back('0);
      last_r = '0;
      last_s = '1;
   endtask

   // driver: one clock of input, then check the output leaving the pipe this cycle
   task automatic step(input logic av, input logic [W+1:0] zv);
      logic [EW-1:0] e;
      in_avail = av;
      z        = zv;
      in_side  = zv[SW-1:0];
      exp_q.push_back({av, ref_mod(zv), zv[SW-1:0]});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (e[EW-1]) begin
         last_r = e[W+SW-1:SW];
         last_s = e[SW-1:0];
      end
      chk("out_avail", 128'(out_avail), 128'(e[EW-1]));
      chk("r", 128'(r), 128'(last_r));
      chk("out_side", 128'(out_side), 128'(last_s));
   endtask

   task automatic single(input string tag, input logic [W+1:0] zv, input logic [W-1:0] exp_r);
      step(1'b1, zv);
      repeat (LAT - 1) step(1'b0, rand_z());
      chk(tag, 128'(r), 128'(exp_r));
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      mm       = 66'h0_FFFF_FFFF_0000_0001;
      bnd[0]   = '0;
      bnd[1]   = mm;
      bnd[2]   = mm << 1;
      bnd[3]   = -mm;
      bnd[4]   = -(mm << 1);
      bnd[5]   = '1;
      bnd[6]   = 66'h1_FFFF_FFFF_FFFF_FFFF;
      bnd[7]   = 66'h2_0000_0000_0000_0000;
      bnd[8]   = (mm << 1) - 66'd1;
      bnd[9]   = mm - 66'd1;

      a_rst    = 1'b1;
      in_avail = 1'b0;
      z        = '0;
      in_side  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_avail", 128'(out_avail), 128'(0));
      chk("rst_r", 128'(r), 128'(0));
      chk("rst_out_side", 128'(out_side), 128'(8'hFF));
      model_reset();
      a_rst = 1'b0;

      // single operands and range extremes against fixed residues
      single("z_zero",     '0,                          64'h0);
      single("z_m",        mm,                          64'h0);
      single("z_2m_m1",    (mm << 1) - 66'd1,           64'hFFFF_FFFF_0000_0000);
      single("z_max",      66'h1_FFFF_FFFF_FFFF_FFFF,   64'h1_FFFF_FFFD);
      single("z_min",      66'h2_0000_0000_0000_0000,   64'hFFFF_FFFD_0000_0003);
      single("z_neg1",     '1,                          64'hFFFF_FFFF_0000_0000);
      single("z_neg_m",    -mm,                         64'h0);
      single("z_2m",       mm << 1,                     64'h0);
      single("z_neg_2m",   -(mm << 1),                  64'h0);

      // gapped pattern reproduced LAT cycles later, with held outputs in the gaps
      step(1'b1, rand_z());
      step(1'b0, rand_z());
      step(1'b0, rand_z());
      step(1'b1, rand_z());
      step(1'b1, rand_z());
      step(1'b0, rand_z());
      step(1'b1, rand_z());
      repeat (LAT + 1) step(1'b0, rand_z());

      // random gaps
      repeat (400) step(1'($urandom_range(0, 1)), rand_z());

      // mid-stream asynchronous reset with operands in flight
      repeat (3) step(1'b1, rand_z());
      #2;
      a_rst = 1'b1;
      #1;
      chk("midrst_out_avail", 128'(out_avail), 128'(0));
      chk("midrst_r", 128'(r), 128'(0));
      chk("midrst_out_side", 128'(out_side), 128'(8'hFF));
      model_reset();
      @(negedge clk);
      a_rst = 1'b0;
      repeat (LAT + 1) step(1'b0, rand_z());
      single("post_rst", 66'h1_FFFF_FFFF_FFFF_FFFF, 64'h1_FFFF_FFFD);

      // back-to-back streaming
      repeat (4000) step(1'b1, rand_z());
      repeat (LAT) step(1'b0, rand_z());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
